// File: rtl/pointer_pair_pkg.sv
// pointer_pair shared widths and types.
// Imported by the interface, the pointer register and the top.
package pointer_pair_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/pointer_pair_if.sv
// Control bundle for pointer_pair: data-in, write/count, role select, OEs.
// master drives the controls, slave (the pointer pair) consumes them.
interface pointer_pair_if;
    import pointer_pair_pkg::*;

    data_t di;
    logic  we_l;
    logic  we_h;
    logic  cnt;
    logic  selector;
    logic  oe_addr_ip;
    logic  oe_addr_dp;
    logic  oe_dl;
    logic  oe_dh;

    modport master (
        output di, we_l, we_h, cnt, selector,
        output oe_addr_ip, oe_addr_dp, oe_dl, oe_dh
    );

    modport slave (
        input di, we_l, we_h, cnt, selector,
        input oe_addr_ip, oe_addr_dp, oe_dl, oe_dh
    );

endinterface

// File: rtl/pointer_pair_reg.sv
// pointer_reg: 16-bit register, async active-low clear, per-byte
// active-low load from di, active-high increment. Ports: clk, rst_n, di,
// we_l, we_h, inc, q.
module pointer_reg
    import pointer_pair_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  data_t di,
    input  logic  we_l,
    input  logic  we_h,
    input  logic  inc,
    output addr_t q
);

    // The top never asserts inc together with a write on one instance,
    // so increment simply takes precedence here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc) begin
            q <= q + addr_t'(1);
        end else begin
            if (!we_l) q[DATA_W-1:0]      <= di;
            if (!we_h) q[ADDR_W-1:DATA_W] <= di;
        end
    end

endmodule

// File: rtl/pointer_pair.sv
// pointer_pair: IP/DP pair over physical regs P0/P1, role-swapped by
// selector. Ports: clk, rst (async active-low), bus (controls),
// addr_out (tri 16), data_out (tri 8).
module pointer_pair
    import pointer_pair_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pointer_pair_if.slave       bus,
    output tri   [ADDR_W-1:0]   addr_out,
    output tri   [DATA_W-1:0]   data_out
);

    addr_t p0_q;
    addr_t p1_q;
    addr_t ip;
    addr_t dp;

    // selector=0: P0 is IP, P1 is DP; selector=1 swaps them.
    logic p0_is_ip;
    assign p0_is_ip = ~bus.selector;

    // Write enables are active-low: force high unless the reg is DP.
    logic p0_we_l, p0_we_h, p0_inc;
    logic p1_we_l, p1_we_h, p1_inc;

    assign p0_we_l = bus.we_l | p0_is_ip;
    assign p0_we_h = bus.we_h | p0_is_ip;
    assign p0_inc  = bus.cnt  & p0_is_ip;

    assign p1_we_l = bus.we_l | ~p0_is_ip;
    assign p1_we_h = bus.we_h | ~p0_is_ip;
    assign p1_inc  = bus.cnt  & ~p0_is_ip;

    pointer_reg u_p0 (
        .clk   (clk),
        .rst_n (rst),
        .di    (bus.di),
        .we_l  (p0_we_l),
        .we_h  (p0_we_h),
        .inc   (p0_inc),
        .q     (p0_q)
    );

    pointer_reg u_p1 (
        .clk   (clk),
        .rst_n (rst),
        .di    (bus.di),
        .we_l  (p1_we_l),
        .we_h  (p1_we_h),
        .inc   (p1_inc),
        .q     (p1_q)
    );

    assign ip = p0_is_ip ? p0_q : p1_q;
    assign dp = p0_is_ip ? p1_q : p0_q;

    logic  addr_en;
    addr_t addr_val;
    logic  data_en;
    data_t data_val;

    // IP wins over DP and low byte wins over high byte, so the pair
    // never fights itself on either bus.
    always_comb begin
        addr_en  = 1'b0;
        addr_val = '0;
        if (!bus.oe_addr_ip) begin
            addr_en  = 1'b1;
            addr_val = ip;
        end else if (!bus.oe_addr_dp) begin
            addr_en  = 1'b1;
            addr_val = dp;
        end
    end

    always_comb begin
        data_en  = 1'b0;
        data_val = '0;
        if (!bus.oe_dl) begin
            data_en  = 1'b1;
            data_val = dp[DATA_W-1:0];
        end else if (!bus.oe_dh) begin
            data_en  = 1'b1;
            data_val = dp[ADDR_W-1:DATA_W];
        end
    end

    assign addr_out = addr_en ? addr_val : {ADDR_W{1'bz}};
    assign data_out = data_en ? data_val : {DATA_W{1'bz}};

endmodule

// File: tb/tb_pointer_pair.sv
// Bench for pointer_pair: directed vector table, async-reset sequence,
// then random traffic against an IP/DP reference model.
module tb_pointer_pair;
    import pointer_pair_pkg::*;

    logic clk;
    logic rst;
    tri [15:0] addr_bus;
    tri [7:0]  data_bus;

    // Probe drivers: when the DUT should float, the bench drives known
    // patterns and expects to read exactly them back.
    logic        pa_en;
    logic [15:0] pa_val;
    logic        pd_en;
    logic [7:0]  pd_val;

    assign addr_bus = pa_en ? pa_val : 16'hzzzz;
    assign data_bus = pd_en ? pd_val : 8'hzz;

    pointer_pair_if bus ();

    pointer_pair dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .addr_out (addr_bus),
        .data_out (data_bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        logic        sel;
        logic        we_l;
        logic        we_h;
        logic        cnt;
        logic [7:0]  di;
        logic        oe_ip;
        logic        oe_dp;
        logic        oe_dl;
        logic        oe_dh;
        logic [15:0] ea;
        bit          az;
        logic [7:0]  ed;
        bit          dz;
    } vec_t;

    function automatic vec_t mk(
        logic sel, logic we_l, logic we_h, logic cnt, logic [7:0] di,
        logic oe_ip, logic oe_dp, logic oe_dl, logic oe_dh,
        logic [15:0] ea, bit az, logic [7:0] ed, bit dz);
        vec_t v;
        v.sel = sel; v.we_l = we_l; v.we_h = we_h; v.cnt = cnt;
        v.di = di; v.oe_ip = oe_ip; v.oe_dp = oe_dp;
        v.oe_dl = oe_dl; v.oe_dh = oe_dh;
        v.ea = ea; v.az = az; v.ed = ed; v.dz = dz;
        return v;
    endfunction

    task automatic drive(
        logic sel, logic we_l, logic we_h, logic cnt, logic [7:0] di,
        logic oe_ip, logic oe_dp, logic oe_dl, logic oe_dh);
        bus.selector   = sel;
        bus.we_l       = we_l;
        bus.we_h       = we_h;
        bus.cnt        = cnt;
        bus.di         = di;
        bus.oe_addr_ip = oe_ip;
        bus.oe_addr_dp = oe_dp;
        bus.oe_dl      = oe_dl;
        bus.oe_dh      = oe_dh;
    endtask

    task automatic check_addr(string tag, logic [15:0] ea, bit az);
        logic [15:0] r1, r2;
        checks++;
        if (az) begin
            pa_en = 1'b1; pa_val = 16'h5A5A; #1; r1 = addr_bus;
            pa_val = 16'hA5A5; #1; r2 = addr_bus;
            pa_en = 1'b0; #1;
            if (r1 !== 16'h5A5A || r2 !== 16'hA5A5) begin
                failures++;
                $display("FAIL %s addr: read %h/%h, required Z", tag, r1, r2);
            end
        end else begin
            #1;
            if (addr_bus !== ea) begin
                failures++;
                $display("FAIL %s addr: got %h, required %h", tag, addr_bus, ea);
            end
        end
    endtask

    task automatic check_data(string tag, logic [7:0] ed, bit dz);
        logic [7:0] r1, r2;
        checks++;
        if (dz) begin
            pd_en = 1'b1; pd_val = 8'h5A; #1; r1 = data_bus;
            pd_val = 8'hA5; #1; r2 = data_bus;
            pd_en = 1'b0; #1;
            if (r1 !== 8'h5A || r2 !== 8'hA5) begin
                failures++;
                $display("FAIL %s data: read %h/%h, required Z", tag, r1, r2);
            end
        end else begin
            #1;
            if (data_bus !== ed) begin
                failures++;
                $display("FAIL %s data: got %h, required %h", tag, data_bus, ed);
            end
        end
    endtask

    // Reference model: two plain integers, role picked by selector.
    int unsigned p[2];

    task automatic model_expect(
        logic sel, logic oe_ip, logic oe_dp, logic oe_dl, logic oe_dh,
        output logic [15:0] ea, output bit az,
        output logic [7:0] ed, output bit dz);
        int unsigned ipv, dpv;
        ipv = p[sel ? 1 : 0];
        dpv = p[sel ? 0 : 1];
        az = 1'b0; dz = 1'b0; ea = '0; ed = '0;
        if (!oe_ip)      ea = 16'(ipv);
        else if (!oe_dp) ea = 16'(dpv);
        else             az = 1'b1;
        if (!oe_dl)      ed = 8'(dpv % 256);
        else if (!oe_dh) ed = 8'(dpv / 256);
        else             dz = 1'b1;
    endtask

    task automatic model_edge(
        logic sel, logic we_l, logic we_h, logic cnt, logic [7:0] di);
        int ii, di_idx;
        int unsigned lo, hi;
        ii = sel ? 1 : 0;
        di_idx = sel ? 0 : 1;
        lo = p[di_idx] % 256;
        hi = p[di_idx] / 256;
        if (!we_l) lo = di;
        if (!we_h) hi = di;
        p[di_idx] = hi * 256 + lo;
        if (cnt) p[ii] = (p[ii] + 1) % 65536;
    endtask

    vec_t vt[15];

    initial begin
        checks = 0;
        failures = 0;
        pa_en = 1'b0; pa_val = '0;
        pd_en = 1'b0; pd_val = '0;
        drive(0, 1, 1, 0, 8'h00, 1, 1, 1, 1);
        rst = 1'b0;

        vt[0]  = mk(0,1,1,0,8'h00, 1,1,1,1, 16'h0000,1, 8'h00,1);
        vt[1]  = mk(0,1,1,0,8'h00, 0,1,1,1, 16'h0000,0, 8'h00,1);
        vt[2]  = mk(0,0,1,0,8'hFE, 0,1,1,1, 16'h0000,0, 8'h00,1);
        vt[3]  = mk(0,1,1,0,8'h00, 0,1,0,1, 16'h0000,0, 8'hFE,0);
        vt[4]  = mk(0,1,1,1,8'h00, 0,1,1,0, 16'h0000,0, 8'h00,0);
        vt[5]  = mk(0,1,1,1,8'h00, 0,1,1,1, 16'h0001,0, 8'h00,1);
        vt[6]  = mk(0,1,1,0,8'h00, 1,0,1,1, 16'h00FE,0, 8'h00,1);
        vt[7]  = mk(1,1,1,0,8'h00, 1,0,1,1, 16'h0002,0, 8'h00,1);
        vt[8]  = mk(1,1,1,0,8'h00, 0,1,0,1, 16'h00FE,0, 8'h02,0);
        vt[9]  = mk(1,1,0,1,8'hFF, 0,0,0,0, 16'h00FE,0, 8'h02,0);
        vt[10] = mk(1,1,1,0,8'h00, 1,0,1,0, 16'hFF02,0, 8'hFF,0);
        vt[11] = mk(1,1,1,0,8'h00, 0,1,1,1, 16'h00FF,0, 8'h00,1);
        vt[12] = mk(0,0,0,0,8'hFF, 1,0,1,1, 16'h00FF,0, 8'h00,1);
        vt[13] = mk(1,1,1,1,8'h00, 0,1,1,1, 16'hFFFF,0, 8'h00,1);
        vt[14] = mk(1,1,1,0,8'h00, 0,1,0,1, 16'h0000,0, 8'h02,0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vt[i].sel, vt[i].we_l, vt[i].we_h, vt[i].cnt, vt[i].di,
                  vt[i].oe_ip, vt[i].oe_dp, vt[i].oe_dl, vt[i].oe_dh);
            check_addr($sformatf("vec%0d", i), vt[i].ea, vt[i].az);
            check_data($sformatf("vec%0d", i), vt[i].ed, vt[i].dz);
        end

        // Async reset mid-cycle: P0=FF02, P1=0000 at this point.
        @(negedge clk);
        drive(1, 1, 1, 0, 8'h00, 1, 0, 1, 0);
        check_addr("pre_rst", 16'hFF02, 0);
        check_data("pre_rst", 8'hFF, 0);
        rst = 1'b0;
        check_addr("async_rst", 16'h0000, 0);
        check_data("async_rst", 8'h00, 0);
        drive(1, 0, 0, 1, 8'h55, 0, 1, 0, 1);
        repeat (2) @(posedge clk);
        #2;
        check_addr("rst_hold_ip", 16'h0000, 0);
        check_data("rst_hold_dp", 8'h00, 0);
        @(negedge clk);
        drive(0, 1, 1, 0, 8'h00, 1, 0, 1, 0);
        rst = 1'b1;
        check_addr("post_rst", 16'h0000, 0);
        check_data("post_rst", 8'h00, 0);

        p[0] = 0;
        p[1] = 0;
        for (int n = 0; n < 400; n++) begin
            logic        s, wl, wh, c, oi, od, ol, oh;
            logic [7:0]  d;
            logic [15:0] ea;
            logic [7:0]  ed;
            bit          az, dz;
            @(negedge clk);
            s  = 1'($urandom_range(0, 1));
            wl = ($urandom_range(0, 2) != 0);
            wh = ($urandom_range(0, 2) != 0);
            c  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            oi = 1'($urandom_range(0, 1));
            od = 1'($urandom_range(0, 1));
            ol = 1'($urandom_range(0, 1));
            oh = 1'($urandom_range(0, 1));
            drive(s, wl, wh, c, d, oi, od, ol, oh);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
                p[0] = 0;
                p[1] = 0;
            end
            model_expect(s, oi, od, ol, oh, ea, az, ed, dz);
            check_addr($sformatf("rnd%0d", n), ea, az);
            check_data($sformatf("rnd%0d", n), ed, dz);
            @(posedge clk);
            model_edge(s, wl, wh, c, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
